// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
package md_pkg;

  // Default operand/result width and iteration counter width.
  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 6;

  // Operation encodings driven by decode; 2'b11 is reserved and runs as mul.
  localparam logic [1:0] MD_MUL  = 2'b00;
  localparam logic [1:0] MD_DIVU = 2'b01;
  localparam logic [1:0] MD_REMU = 2'b10;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // True for the operations that use the restoring divider.
  function automatic logic is_div(input logic [1:0] op);
    return (op == MD_DIVU) || (op == MD_REMU);
  endfunction

endpackage

// File: rtl/md_datapath.sv
// Radix-2 shift registers shared by shift-add multiply and restoring divide.
// acc_q  : upper product half / partial remainder
// lo_q   : multiplier (shifted out LSB first) / quotient (shifted in LSB)
// opnd_q : multiplicand / divisor, constant for the whole operation
module md_datapath
  import md_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            div_mode,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic [XLEN-1:0] step_acc;
  logic [XLEN-1:0] step_lo;

  // One iteration of the selected algorithm, computed from the current registers.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    div_shift = {acc_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    step_acc  = acc_q;
    step_lo   = lo_q;
    if (div_mode) begin
      // The top bit of the difference is the borrow: keep the difference only without it.
      if (!div_diff[XLEN]) begin
        step_acc = div_diff[XLEN-1:0];
        step_lo  = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        step_acc = div_shift[XLEN-1:0];
        step_lo  = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      // Product {acc, lo} shifts right by one with the partial sum's carry entering at the top.
      step_acc = mul_sum[XLEN:1];
      step_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Register next-state: load operands on acceptance, advance on each step, otherwise hold.
  always_comb begin
    acc_d  = acc_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    if (load) begin
      acc_d  = '0;
      lo_d   = div_mode ? operand_a : operand_b;
      opnd_d = div_mode ? operand_b : operand_a;
    end else if (step) begin
      acc_d = step_acc;
      lo_d  = step_lo;
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else begin
      acc_q  <= acc_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
    end
  end

  // The sequencer captures the post-iteration values on the final step.
  assign acc_next = step_acc;
  assign lo_next  = step_lo;

endmodule

// File: rtl/md_sequencer.sv
// Iterative mul/divu/remu unit beside the execute-stage ALU. Stalls the pipeline
// while running, then presents a registered result with a one-cycle done pulse.
// CNT_W must satisfy 2**CNT_W > XLEN so the counter can hold XLEN-1.
module md_sequencer
  import md_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic            flush,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  md_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            accept;
  logic            div_by_zero;
  logic            dp_step;
  logic            dp_div_mode;
  logic [XLEN-1:0] dp_acc_next;
  logic [XLEN-1:0] dp_lo_next;

  // A request is taken only from IDLE and never in the same cycle as a flush.
  assign accept      = (state_q == IDLE) && start && !flush;
  assign div_by_zero = is_div(op) && (operand_b == '0);
  assign dp_step     = (state_q == RUN) && !flush;
  // While loading, the mode follows the incoming op; afterwards the latched op.
  assign dp_div_mode = (state_q == IDLE) ? is_div(op) : is_div(op_q);

  md_datapath #(
    .XLEN(XLEN)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .step     (dp_step),
    .div_mode (dp_div_mode),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .acc_next (dp_acc_next),
    .lo_next  (dp_lo_next)
  );

  // Next-state, counter and result capture; result changes only when entering DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = op;
          cnt_d = CNT_W'(XLEN - 1);
          if (div_by_zero) begin
            // Divide by zero short-circuits: quotient all ones, remainder is the dividend.
            state_d  = DONE;
            result_d = (op == MD_DIVU) ? {XLEN{1'b1}} : operand_a;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d  = DONE;
          result_d = (op_q == MD_REMU) ? dp_acc_next : dp_lo_next;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers with synchronous reset taking priority over flush and start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= MD_MUL;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  // Stall is low in DONE so the held instruction retires alongside the result.
  assign stall  = accept || (state_q == RUN);
  assign busy   = (state_q == RUN) || (state_q == DONE);
  // A flush arriving in DONE cancels the pulse so the aborted instruction never writes back.
  assign done   = (state_q == DONE) && !flush;
  assign result = result_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: each issued op pushes its expected result,
// done cycle and stall count; the negedge monitor pops and compares on done.
module tb_md_sequencer;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  always #5 clk = ~clk;

  md_sequencer #(
    .XLEN (32),
    .CNT_W(6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .flush    (flush),
    .operand_a(a),
    .operand_b(b),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .result   (result)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp_result;
    int          exp_cycle;
    int          exp_stalls;
  } txn_t;

  txn_t sb_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   stall_cnt = 0;
  int   done_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: count stall cycles, and on each done pulse pop and compare one scoreboard entry.
  always @(negedge clk) begin
    txn_t t;
    if (stall) stall_cnt++;
    if (done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        check_eq("unexpected_done", 64'd1, 64'd0);
      end else begin
        t = sb_q.pop_front();
        $display("txn %s result=0x%08h cycle=%0d stalls=%0d", t.tag, result, cyc, stall_cnt);
        check_eq({t.tag, "_result"}, 64'(result), 64'(t.exp_result));
        check_eq({t.tag, "_cycle"}, 64'(cyc), 64'(t.exp_cycle));
        check_eq({t.tag, "_stalls"}, 64'(stall_cnt), 64'(t.exp_stalls));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start pulse; lat is the start-to-done distance in cycles.
  task automatic issue(input string tag, input logic [1:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, input logic [31:0] exp, input int lat);
    txn_t t;
    t.tag        = tag;
    t.exp_result = exp;
    t.exp_cycle  = cyc + lat;
    t.exp_stalls = lat;
    stall_cnt    = 0;
    sb_q.push_back(t);
    start = 1'b1;
    op    = o;
    a     = aa;
    b     = bb;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (sb_q.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      check_eq("timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] aa;
    logic [31:0] bb;
    logic [31:0] prod;
    int d0;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = MD_MUL; a = '0; b = '0;
    repeat (3) tick();
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_result", 64'(result), 64'd0);
    rst = 1'b0;
    tick();

    // Multiply
    issue("mul_7x6", MD_MUL, 32'd7, 32'd6, 32'd42, 33);             wait_drain(40);
    issue("mul_ffx2", MD_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33); wait_drain(40);
    issue("mul_rsvd", 2'b11, 32'd123, 32'd1000, 32'd123000, 33);    wait_drain(40);
    for (int i = 0; i < 3; i++) begin
      aa = $urandom; bb = $urandom; prod = aa * bb;
      issue("mul_rand", MD_MUL, aa, bb, prod, 33); wait_drain(40);
    end

    // Divide / remainder
    issue("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd14, 33);       wait_drain(40);
    issue("remu_100_7", MD_REMU, 32'd100, 32'd7, 32'd2, 33);        wait_drain(40);
    issue("divu_msb_1", MD_DIVU, 32'h8000_0000, 32'd1, 32'h8000_0000, 33); wait_drain(40);
    issue("remu_max", MD_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33); wait_drain(40);
    for (int i = 0; i < 3; i++) begin
      aa = $urandom; bb = 32'($urandom_range(1, 32'h0001_FFFF));
      issue("divu_rand", MD_DIVU, aa, bb, aa / bb, 33); wait_drain(40);
      issue("remu_rand", MD_REMU, aa, bb, aa % bb, 33); wait_drain(40);
    end

    // Divide by zero
    issue("divu_by0", MD_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);     wait_drain(5);
    issue("remu_by0", MD_REMU, 32'd5, 32'd0, 32'd5, 1);             wait_drain(5);

    // Flush at T+10: back to IDLE at T+11, no done, result holds 5
    d0 = done_cnt;
    start = 1'b1; op = MD_DIVU; a = 32'd1000; b = 32'd3;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check_eq("flush_busy", 64'(busy), 64'd0);
    check_eq("flush_result_hold", 64'(result), 64'd5);
    check_eq("flush_no_done", 64'(done_cnt - d0), 64'd0);
    tick();
    issue("after_flush", MD_DIVU, 32'd1000, 32'd3, 32'd333, 33);    wait_drain(40);

    // Second start while busy is ignored; operand changes during RUN are ignored
    d0 = done_cnt;
    issue("restart_ign", MD_MUL, 32'd3, 32'd5, 32'd15, 33);
    repeat (4) tick();
    start = 1'b1; op = MD_DIVU; a = 32'd9; b = 32'd0;
    tick();
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    wait_drain(40);
    repeat (3) tick();
    check_eq("restart_done_count", 64'(done_cnt - d0), 64'd1);

    // Reset mid-RUN
    start = 1'b1; op = MD_DIVU; a = 32'd50; b = 32'd5;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_stall", 64'(stall), 64'd0);
    check_eq("midrst_done", 64'(done), 64'd0);
    check_eq("midrst_result", 64'(result), 64'd0);
    tick();

    // Reset together with start: stays IDLE
    d0 = done_cnt;
    rst = 1'b1; start = 1'b1; op = MD_MUL; a = 32'd2; b = 32'd3;
    tick();
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_eq("rststart_busy", 64'(busy), 64'd0);
    repeat (40) tick();
    check_eq("rststart_no_done", 64'(done_cnt - d0), 64'd0);
    check_eq("rststart_result", 64'(result), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
